// File: rtl/glitch_free_clock_multiplexer.sv
`timescale 1ns/1ps
// Glitch-free 2:1 clock mux: cross-coupled enable chains, last stage on the falling edge.
// Define CLOCK_MULTIPLEXER_RESET_CLOCK_0_EN to have clock_0 forwarded during and straight out of reset.
module glitch_free_clock_multiplexer #(
    parameter int STAGES = 2
) (
    input  logic clock_0,
    input  logic clock_1,
    input  logic resetn,
    input  logic select,
    output logic clock_out
);

`ifdef CLOCK_MULTIPLEXER_RESET_CLOCK_0_EN
    localparam logic RST_0 = 1'b1;
`else
    localparam logic RST_0 = 1'b0;
`endif

    logic enable_0;
    logic enable_1;
    logic req_0;
    logic req_1;
    logic last_0;
    logic last_1;

    assign req_0 = ~select & ~enable_1;
    assign req_1 =  select & ~enable_0;

    generate
        if (STAGES > 1) begin : g_sync
            logic [STAGES-2:0] sync_0;
            logic [STAGES-2:0] sync_1;

            always_ff @(posedge clock_0 or negedge resetn) begin
                if (!resetn) begin
                    sync_0 <= {(STAGES-1){RST_0}};
                end else begin
                    sync_0[0] <= req_0;
                    for (int i = 1; i < STAGES-1; i++) sync_0[i] <= sync_0[i-1];
                end
            end

            always_ff @(posedge clock_1 or negedge resetn) begin
                if (!resetn) begin
                    sync_1 <= '0;
                end else begin
                    sync_1[0] <= req_1;
                    for (int i = 1; i < STAGES-1; i++) sync_1[i] <= sync_1[i-1];
                end
            end

            assign last_0 = sync_0[STAGES-2];
            assign last_1 = sync_1[STAGES-2];
        end else begin : g_direct
            assign last_0 = req_0;
            assign last_1 = req_1;
        end
    endgenerate

    // Final stage re-checks the other enable so a request still in flight after a
    // quick select reversal can never overlap the branch that has taken over.
    always_ff @(negedge clock_0 or negedge resetn) begin
        if (!resetn) enable_0 <= RST_0;
        else         enable_0 <= last_0 & ~enable_1;
    end

    always_ff @(negedge clock_1 or negedge resetn) begin
        if (!resetn) enable_1 <= 1'b0;
        else         enable_1 <= last_1 & ~enable_0;
    end

    assign clock_out = (clock_0 & enable_0) | (clock_1 & enable_1);

endmodule

// File: tb/tb_glitch_free_clock_multiplexer.sv
`timescale 1ns/1ps
// Directed bench for glitch_free_clock_multiplexer: reset, switching, glitch and mid-run reset.
module tb_glitch_free_clock_multiplexer;

    localparam int  STAGES = 2;
    localparam real T0     = 10.0;
    localparam real T1     = 3.184;
    localparam real SETTLE = 2.0 * STAGES * (T0 + T1);
    localparam int  CNT_0  = 100;   // posedges of 100 MHz in 1000 ns
    localparam int  CNT_1  = 314;   // posedges of 1/3.184 ns in 1000 ns
    localparam int  PW_0   = 5000;  // high phase in ps
    localparam int  PW_1   = 1592;

    logic clock_0 = 1'b0;
    logic clock_1 = 1'b0;
    logic resetn  = 1'b0;
    logic select  = 1'b0;
    logic clock_out;

    int      total    = 0;
    int      bad      = 0;
    int      edge_cnt = 0;
    int      pulse_w;
    realtime t_rise   = 0.0;
    bit      rst_seen = 1'b1;

    glitch_free_clock_multiplexer #(.STAGES(STAGES)) dut (
        .clock_0  (clock_0),
        .clock_1  (clock_1),
        .resetn   (resetn),
        .select   (select),
        .clock_out(clock_out)
    );

    always #5 clock_0 = ~clock_0;

    initial begin
        #0.3;
        forever #1.592 clock_1 = ~clock_1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        int tol;
        tol = exp / 20;
        total++;
        if (obs < exp - tol || obs > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d) at %0t", tag, obs, exp, tol, $realtime);
        end
    endtask

    function automatic int rst_exp();
`ifdef CLOCK_MULTIPLEXER_RESET_CLOCK_0_EN
        return int'(clock_0);
`else
        return 0;
`endif
    endfunction

    // Every complete high pulse must be a whole high phase of one source.
    always @(posedge clock_out) begin
        edge_cnt++;
        t_rise   = $realtime;
        rst_seen = 1'b0;
    end

    always @(negedge resetn) rst_seen = 1'b1;

    always @(negedge clock_out) begin
        if (!rst_seen) begin
            pulse_w = int'(($realtime - t_rise) * 1000.0);
            if (pulse_w > 3300) check("high_pulse_0", pulse_w, PW_0);
            else                check("high_pulse_1", pulse_w, PW_1);
        end
    end

    task automatic measure(input string tag, input int exp);
        int n0;
        n0 = edge_cnt;
        #1000;
        check(tag, edge_cnt - n0, exp);
    endtask

    task automatic settle();
        #(SETTLE);
    endtask

    int gaps [3][4] = '{'{700, 1300, 2900, 4100}, '{3000, 9000, 0, 0}, '{250, 6000, 11000, 0}};
    int ntog [3]    = '{4, 2, 3};

    initial begin
        int  n0;
        real waited;

        // reset with select=0, then release
        resetn = 1'b0;
        select = 1'b0;
        #1.3;
        for (int i = 0; i < 5; i++) begin
            check("reset_out", int'(clock_out), rst_exp());
            #3.1;
        end
        #2.3;
        resetn = 1'b1;
        n0     = edge_cnt;
        waited = 0.0;
        while (edge_cnt == n0 && waited < (STAGES + 1) * T0) begin
            #0.5;
            waited += 0.5;
        end
        check("release_latency", int'(edge_cnt != n0), 1);
        measure("freq_after_reset", CNT_0);

        // single switch and back
        select = 1'b1;
        settle();
        measure("freq_sel1", CNT_1);
        select = 1'b0;
        settle();
        measure("freq_sel0", CNT_0);

        // back-and-forth
        for (int i = 0; i < 11; i++) begin
            select = ~select;
            settle();
            if (select) measure("bf_sel1", CNT_1);
            else        measure("bf_sel0", CNT_0);
        end

        // random toggle spacing, pulse monitor active throughout
        for (int i = 0; i < 100; i++) begin
            #(real'($urandom_range(263662, 0)) / 1000.0);
            select = ~select;
        end
        settle();
        if (select) measure("rand_final1", CNT_1);
        else        measure("rand_final0", CNT_0);

        // toggles faster than one handshake
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < ntog[p]; k++) begin
                #(real'(gaps[p][k]) / 1000.0);
                select = ~select;
            end
            settle();
            if (select) measure("burst_final1", CNT_1);
            else        measure("burst_final0", CNT_0);
        end

        // reset asserted inside a clock_0 high phase
        select = 1'b0;
        settle();
        @(posedge clock_out);
        #0.4;
        resetn = 1'b0;
        #0.1;
        check("reset_async", int'(clock_out), rst_exp());
        select = 1'b1;
        #3.0;
        check("reset_hold", int'(clock_out), rst_exp());
        #20;
        resetn = 1'b1;
        settle();
        measure("restart_sel1", CNT_1);

        // reset while clock_1 runs, restart on clock_0
        #0.7;
        resetn = 1'b0;
        select = 1'b0;
        #1.1;
        check("reset_async_1", int'(clock_out), rst_exp());
        #20;
        resetn = 1'b1;
        settle();
        measure("restart_sel0", CNT_0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
